obstacle_engine: RTL and testbench

Per-frame obstacle and progress engine driving the game state machine. It consumes `speed`, `obstacle_count` and `reset_level` from the level controller. It spawns, moves and collision-checks a small pool of obstacles once per video frame, and returns one-cycle `sprite_collision` and `finish_line_reached` pulses. Its obstacle positions and active flags feed the sprite renderer.

---
 rtl/game_pkg.sv | 32 +++
 rtl/obstacle_engine_lfsr8.sv | 19 +
 rtl/obstacle_engine.sv | 229 ++++++++++++++++++++++
 tb/tb_obstacle_engine.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game types and constants: engine FSM states, obstacle slot payload
// and the level controller state encoding.
package game_pkg;

  localparam int unsigned COORD_W    = 10;
  localparam int unsigned SCREEN_W   = 640;
  localparam int unsigned OBJ_SIZE   = 16;
  localparam int unsigned LANE_PITCH = 32;
  localparam logic [7:0]  LFSR_SEED  = 8'hA5;

  typedef enum logic [2:0] {
    ENG_IDLE,
    ENG_MOVE,
    ENG_SPAWN,
    ENG_CHECK,
    ENG_REPORT
  } eng_state_t;

  typedef enum logic [1:0] {
    LVL_ATTRACT,
    LVL_PLAYING,
    LVL_COMPLETE,
    LVL_GAME_OVER
  } level_state_t;

  typedef struct packed {
    logic               active;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } obstacle_t;

endpackage

// File: rtl/obstacle_engine_lfsr8.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) used to pick spawn lanes.
module lfsr8
  import game_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic [7:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= LFSR_SEED;
    end else if (enable) begin
      q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    end
  end

endmodule

// File: rtl/obstacle_engine.sv
// Per-frame obstacle engine: moves, spawns and collision-checks a small pool
// of obstacles once per frame, then reports collision and finish-line pulses.
module obstacle_engine #(
  parameter int unsigned MAX_OBS      = 3,
  parameter int unsigned SCREEN_W     = game_pkg::SCREEN_W,
  parameter int unsigned OBJ_SIZE     = game_pkg::OBJ_SIZE,
  parameter int unsigned FINISH_X     = 600,
  parameter int unsigned SPAWN_PERIOD = 60,
  parameter int unsigned LANE0_Y      = 352
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_tick,
  input  logic [1:0]            speed,
  input  logic [1:0]            obstacle_count,
  input  logic                  reset_level,
  input  logic [9:0]            player_x,
  input  logic [9:0]            player_y,
  output logic                  sprite_collision,
  output logic                  finish_line_reached,
  output logic [MAX_OBS*10-1:0] obs_x,
  output logic [MAX_OBS*10-1:0] obs_y,
  output logic [MAX_OBS-1:0]    obs_active,
  output logic                  busy
);

  import game_pkg::*;

  localparam int unsigned CW = COORD_W;
  localparam int unsigned DW = CW + 1;
  localparam int unsigned IW = (MAX_OBS > 1) ? $clog2(MAX_OBS) : 1;
  localparam int unsigned TW = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(MAX_OBS - 1);
  localparam logic [TW-1:0] TIMER_END = TW'(SPAWN_PERIOD - 1);
  localparam logic [CW-1:0] SPAWN_X   = CW'(SCREEN_W - OBJ_SIZE);
  localparam logic [CW-1:0] FINISH_LIM = CW'(FINISH_X);
  localparam logic [DW-1:0] OBJ_LIM   = DW'(OBJ_SIZE);

  eng_state_t    state, state_n;
  logic [IW-1:0] idx, idx_n;
  obstacle_t     obs_q [MAX_OBS];
  obstacle_t     obs_n [MAX_OBS];
  logic [1:0]    speed_q, speed_n;
  logic [1:0]    count_q, count_n;
  logic [TW-1:0] timer_q, timer_n;
  logic          finished_q, finished_n;
  logic          acc_q, acc_n;
  logic          coll_q, coll_n;
  logic          fin_q, fin_n;
  logic          busy_q, busy_n;
  logic          lfsr_en_c;
  logic [7:0]    lfsr_q;
  logic          lfsr_unused;
  logic [CW-1:0] step;
  logic          placed;
  int unsigned   active_cnt;

  lfsr8 u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .enable (lfsr_en_c),
    .q      (lfsr_q)
  );

  // Only the low two LFSR bits select a lane.
  assign lfsr_unused = ^lfsr_q[7:2];

  // Axis-aligned square overlap using 11-bit signed distances.
  function automatic logic overlap(input obstacle_t o, input logic [CW-1:0] px,
                                   input logic [CW-1:0] py);
    logic signed [DW-1:0] dx, dy;
    logic [DW-1:0]        ax, ay;
    dx = $signed({1'b0, px}) - $signed({1'b0, o.x});
    dy = $signed({1'b0, py}) - $signed({1'b0, o.y});
    ax = dx[DW-1] ? $unsigned(-dx) : $unsigned(dx);
    ay = dy[DW-1] ? $unsigned(-dy) : $unsigned(dy);
    return o.active && (ax < OBJ_LIM) && (ay < OBJ_LIM);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ENG_IDLE;
      idx        <= '0;
      for (int i = 0; i < int'(MAX_OBS); i++) obs_q[i] <= '0;
      speed_q    <= '0;
      count_q    <= '0;
      timer_q    <= '0;
      finished_q <= 1'b0;
      acc_q      <= 1'b0;
      coll_q     <= 1'b0;
      fin_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      for (int i = 0; i < int'(MAX_OBS); i++) obs_q[i] <= obs_n[i];
      speed_q    <= speed_n;
      count_q    <= count_n;
      timer_q    <= timer_n;
      finished_q <= finished_n;
      acc_q      <= acc_n;
      coll_q     <= coll_n;
      fin_q      <= fin_n;
      busy_q     <= busy_n;
    end
  end

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    obs_n      = obs_q;
    speed_n    = speed_q;
    count_n    = count_q;
    timer_n    = timer_q;
    finished_n = finished_q;
    acc_n      = acc_q;
    coll_n     = 1'b0;
    fin_n      = 1'b0;
    lfsr_en_c  = 1'b0;
    placed     = 1'b0;
    active_cnt = 0;
    step       = CW'({speed_q, 1'b0});

    unique case (state)
      ENG_IDLE: begin
        if (frame_tick) begin
          speed_n   = speed;
          count_n   = obstacle_count;
          lfsr_en_c = 1'b1;
          acc_n     = 1'b0;
          idx_n     = '0;
          state_n   = ENG_MOVE;
        end
      end

      ENG_MOVE: begin
        // Compare before subtracting so x never wraps below zero.
        for (int i = 0; i < int'(MAX_OBS); i++) begin
          if (IW'(i) == idx && obs_q[i].active) begin
            if (obs_q[i].x < step) obs_n[i].active = 1'b0;
            else                   obs_n[i].x      = obs_q[i].x - step;
          end
        end
        if (idx == LAST_IDX) begin
          idx_n   = '0;
          state_n = ENG_SPAWN;
        end else begin
          idx_n = idx + IW'(1);
        end
      end

      ENG_SPAWN: begin
        if (speed_q != 2'd0 && timer_q == TIMER_END) begin
          timer_n = '0;
          for (int i = 0; i < int'(MAX_OBS); i++) begin
            if (obs_q[i].active) active_cnt = active_cnt + 1;
          end
          if (active_cnt < 32'(count_q)) begin
            for (int i = 0; i < int'(MAX_OBS); i++) begin
              if (!placed && !obs_q[i].active) begin
                obs_n[i].active = 1'b1;
                obs_n[i].x      = SPAWN_X;
                obs_n[i].y      = CW'(LANE0_Y + LANE_PITCH * 32'(lfsr_q[1:0]));
                placed          = 1'b1;
              end
            end
          end
        end else if (speed_q != 2'd0) begin
          timer_n = timer_q + TW'(1);
        end
        idx_n   = '0;
        state_n = ENG_CHECK;
      end

      ENG_CHECK: begin
        for (int i = 0; i < int'(MAX_OBS); i++) begin
          if (IW'(i) == idx && overlap(obs_q[i], player_x, player_y)) acc_n = 1'b1;
        end
        // Pulses are registered on entry to REPORT so they are visible there.
        if (idx == LAST_IDX) begin
          idx_n   = '0;
          state_n = ENG_REPORT;
          coll_n  = acc_n;
          if (player_x >= FINISH_LIM && !finished_q) begin
            fin_n      = 1'b1;
            finished_n = 1'b1;
          end
        end else begin
          idx_n = idx + IW'(1);
        end
      end

      ENG_REPORT: begin
        state_n = ENG_IDLE;
      end

      default: begin
        state_n = ENG_IDLE;
      end
    endcase

    if (reset_level) begin
      state_n    = ENG_IDLE;
      idx_n      = '0;
      for (int i = 0; i < int'(MAX_OBS); i++) obs_n[i].active = 1'b0;
      timer_n    = '0;
      finished_n = 1'b0;
      acc_n      = 1'b0;
      coll_n     = 1'b0;
      fin_n      = 1'b0;
      lfsr_en_c  = 1'b0;
      speed_n    = speed_q;
      count_n    = count_q;
    end

    busy_n = (state_n != ENG_IDLE);
  end

  for (genvar g = 0; g < int'(MAX_OBS); g++) begin : g_slot
    assign obs_x[g*10 +: 10] = obs_q[g].x;
    assign obs_y[g*10 +: 10] = obs_q[g].y;
    assign obs_active[g]     = obs_q[g].active;
  end

  assign sprite_collision    = coll_q;
  assign finish_line_reached = fin_q;
  assign busy                = busy_q;

endmodule

// File: tb/tb_obstacle_engine.sv
// Self-checking bench for obstacle_engine: hand-computed frame table, corner
// sequences and randomized frames against a per-frame behavioural model.
module tb_obstacle_engine;

  localparam int NOBS = 3;
  localparam int SP   = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            frame_tick = 1'b0;
  logic [1:0]      speed = '0;
  logic [1:0]      obstacle_count = '0;
  logic            reset_level = 1'b0;
  logic [9:0]      player_x = '0;
  logic [9:0]      player_y = '0;
  logic            sprite_collision;
  logic            finish_line_reached;
  logic [NOBS*10-1:0] obs_x;
  logic [NOBS*10-1:0] obs_y;
  logic [NOBS-1:0] obs_active;
  logic            busy;

  obstacle_engine #(.MAX_OBS(NOBS), .SPAWN_PERIOD(SP)) dut (
    .clk                 (clk),
    .reset               (reset),
    .frame_tick          (frame_tick),
    .speed               (speed),
    .obstacle_count      (obstacle_count),
    .reset_level         (reset_level),
    .player_x            (player_x),
    .player_y            (player_y),
    .sprite_collision    (sprite_collision),
    .finish_line_reached (finish_line_reached),
    .obs_x               (obs_x),
    .obs_y               (obs_y),
    .obs_active          (obs_active),
    .busy                (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model of the level, advanced one whole frame at a time.
  int         m_x [NOBS];
  int         m_y [NOBS];
  bit         m_act [NOBS];
  int         m_timer;
  bit         m_finished;
  logic [7:0] m_lfsr;
  bit         m_coll;
  bit         m_fin;

  typedef struct {
    int spd; int cnt; int px; int py;
    bit act0; int x0; int y0; bit coll; bit fin;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_reset_level();
    for (int i = 0; i < NOBS; i++) m_act[i] = 1'b0;
    m_timer    = 0;
    m_finished = 1'b0;
  endtask

  task automatic model_frame(input int spd, input int cnt, input int px, input int py);
    int n;
    bit done;
    m_lfsr = lfsr_next(m_lfsr);
    for (int i = 0; i < NOBS; i++) begin
      if (m_act[i]) begin
        if (m_x[i] < 2 * spd) m_act[i] = 1'b0;
        else                  m_x[i] = m_x[i] - 2 * spd;
      end
    end
    if (spd != 0) begin
      if (m_timer == SP - 1) begin
        m_timer = 0;
        n = 0;
        for (int i = 0; i < NOBS; i++) n += int'(m_act[i]);
        done = 1'b0;
        if (n < cnt) begin
          for (int i = 0; i < NOBS; i++) begin
            if (!done && !m_act[i]) begin
              m_act[i] = 1'b1;
              m_x[i]   = 640 - 16;
              m_y[i]   = 352 + 32 * int'(m_lfsr[1:0]);
              done     = 1'b1;
            end
          end
        end
      end else begin
        m_timer++;
      end
    end
    m_coll = 1'b0;
    for (int i = 0; i < NOBS; i++) begin
      if (m_act[i] && iabs(px - m_x[i]) < 16 && iabs(py - m_y[i]) < 16) m_coll = 1'b1;
    end
    m_fin = (px >= 600) && !m_finished;
    if (m_fin) m_finished = 1'b1;
  endtask

  task automatic check_slots(input string tag);
    for (int i = 0; i < NOBS; i++) begin
      check($sformatf("%s_active%0d", tag, i), int'(obs_active[i]), int'(m_act[i]));
      if (m_act[i]) begin
        check($sformatf("%s_x%0d", tag, i), int'(obs_x[i*10 +: 10]), m_x[i]);
        check($sformatf("%s_y%0d", tag, i), int'(obs_y[i*10 +: 10]), m_y[i]);
      end
    end
  endtask

  // One frame: tick accepted at cycle T, pulses expected only at T+8.
  task automatic run_frame(input int spd, input int cnt, input int px, input int py,
                           input bit extra_tick, output bit c, output bit f);
    int busy_low;
    bit early;
    @(negedge clk);
    speed = 2'(spd); obstacle_count = 2'(cnt);
    player_x = 10'(px); player_y = 10'(py);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    model_frame(spd, cnt, px, py);
    busy_low = 0; early = 1'b0; c = 1'b0; f = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) @(negedge clk);
      if (extra_tick) frame_tick = (k == 3);
      if (!busy) busy_low++;
      if (k < 8 && (sprite_collision || finish_line_reached)) early = 1'b1;
      if (k == 8) begin c = sprite_collision; f = finish_line_reached; end
    end
    frame_tick = 1'b0;
    check("busy_window", busy_low, 0);
    check("early_pulse", int'(early), 0);
    check("sprite_collision", int'(c), int'(m_coll));
    check("finish_line_reached", int'(f), int'(m_fin));
    @(negedge clk);
    check("busy_after_report", int'(busy), 0);
    check("pulse_one_cycle", int'(sprite_collision | finish_line_reached), 0);
    if (extra_tick) begin
      @(negedge clk);
      check("tick_while_busy_ignored", int'(busy), 0);
    end
    check_slots("slot");
  endtask

  task automatic level_reset();
    @(negedge clk);
    reset_level = 1'b1;
    @(negedge clk);
    reset_level = 1'b0;
    model_reset_level();
    check("level_reset_active", int'(obs_active), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    bit c, f;
    int guard, px, py, j;
    int quiet;

    tbl[0] = '{spd:1, cnt:1, px:0,   py:0,   act0:0, x0:0,   y0:0,   coll:0, fin:0};
    tbl[1] = '{spd:1, cnt:1, px:0,   py:0,   act0:1, x0:624, y0:384, coll:0, fin:0};
    tbl[2] = '{spd:3, cnt:1, px:0,   py:0,   act0:1, x0:618, y0:384, coll:0, fin:0};
    tbl[3] = '{spd:3, cnt:1, px:0,   py:0,   act0:1, x0:612, y0:384, coll:0, fin:0};
    tbl[4] = '{spd:0, cnt:1, px:0,   py:0,   act0:1, x0:612, y0:384, coll:0, fin:0};
    tbl[5] = '{spd:3, cnt:1, px:600, py:384, act0:1, x0:606, y0:384, coll:1, fin:1};
    tbl[6] = '{spd:3, cnt:1, px:600, py:384, act0:1, x0:600, y0:384, coll:1, fin:0};
    tbl[7] = '{spd:3, cnt:1, px:578, py:384, act0:1, x0:594, y0:384, coll:0, fin:0};

    for (int i = 0; i < NOBS; i++) begin m_x[i] = 0; m_y[i] = 0; m_act[i] = 0; end
    m_timer = 0; m_finished = 0; m_lfsr = 8'hA5;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_collision", int'(sprite_collision), 0);
    check("reset_finish", int'(finish_line_reached), 0);
    check("reset_active", int'(obs_active), 0);
    check("reset_obs_x", int'(obs_x != '0), 0);
    check("reset_obs_y", int'(obs_y != '0), 0);

    // Hand-computed frame table from reset.
    for (int r = 0; r < 8; r++) begin
      run_frame(tbl[r].spd, tbl[r].cnt, tbl[r].px, tbl[r].py, 1'b0, c, f);
      check($sformatf("tbl%0d_act0", r), int'(obs_active[0]), int'(tbl[r].act0));
      if (tbl[r].act0) begin
        check($sformatf("tbl%0d_x0", r), int'(obs_x[9:0]), tbl[r].x0);
        check($sformatf("tbl%0d_y0", r), int'(obs_y[9:0]), tbl[r].y0);
      end
      check($sformatf("tbl%0d_others", r), int'(obs_active[NOBS-1:1]), 0);
      check($sformatf("tbl%0d_coll", r), int'(c), int'(tbl[r].coll));
      check($sformatf("tbl%0d_fin", r), int'(f), int'(tbl[r].fin));
    end

    // frame_tick while busy is ignored.
    run_frame(3, 1, 0, 0, 1'b1, c, f);

    // Finish line pulses again after a level reset.
    level_reset();
    run_frame(3, 1, 600, 0, 1'b0, c, f);
    check("finish_after_level_reset", int'(f), 1);

    // reset_level in the middle of CHECK suppresses the frame's pulses.
    level_reset();
    run_frame(1, 1, 0, 0, 1'b0, c, f);
    @(negedge clk);
    speed = 2'd1; obstacle_count = 2'd1; player_x = 10'd600; player_y = 10'd0;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    model_frame(1, 1, 600, 0);
    repeat (4) @(negedge clk);
    reset_level = 1'b1;
    @(negedge clk);
    reset_level = 1'b0;
    model_reset_level();
    check("midcheck_active", int'(obs_active), 0);
    check("midcheck_busy", int'(busy), 0);
    quiet = 0;
    for (int k = 0; k < 5; k++) begin
      if (sprite_collision || finish_line_reached || busy) quiet++;
      if (k < 4) @(negedge clk);
    end
    check("midcheck_no_pulse", quiet, 0);
    run_frame(1, 1, 600, 0, 1'b0, c, f);
    check("finish_after_midcheck", int'(f), 1);

    // Walk one obstacle down to x=4, then a speed-3 frame must retire it.
    level_reset();
    guard = 0;
    while (!(m_act[0] && m_x[0] == 4) && guard < 400) begin
      run_frame(2, 1, 0, 0, 1'b0, c, f);
      guard++;
    end
    check("reach_x4_in_budget", int'(guard < 400), 1);
    run_frame(3, 0, 0, 0, 1'b0, c, f);
    check("deactivate_at_x4", int'(obs_active[0]), 0);
    for (int k = 0; k < 3; k++) begin
      run_frame(3, 0, 0, 0, 1'b0, c, f);
      check("count0_no_spawn", int'(obs_active), 0);
    end

    // Speed 0 never spawns.
    level_reset();
    for (int k = 0; k < 4; k++) begin
      run_frame(0, 3, 0, 0, 1'b0, c, f);
      check("speed0_no_spawn", int'(obs_active), 0);
    end

    // Randomized frames against the model.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 24) == 0) level_reset();
      j = int'($urandom_range(0, NOBS - 1));
      if (m_act[j] && $urandom_range(0, 1) == 1) begin
        px = m_x[j] - 2 * 3 + int'($urandom_range(0, 40)) - 20;
        py = m_y[j] + int'($urandom_range(0, 40)) - 20;
      end else begin
        px = int'($urandom_range(0, 1023));
        py = int'($urandom_range(300, 500));
      end
      if (px < 0) px = 0;
      if (px > 1023) px = 1023;
      if (py < 0) py = 0;
      if (py > 1023) py = 1023;
      run_frame(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), px, py,
                1'b0, c, f);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
